// File: rtl/lut_neuron_pkg.sv
// Shared types and sizing helpers for the LUT neuron array.
// Optional feature macro: LUT_PARITY_EN (adds one even-parity bit per table entry).
package lut_neuron_pkg;

  // Controller states: unprogrammed, draining the pipeline, loading tables, running lookups.
  typedef enum logic [1:0] {
    UNPROG = 2'd0,
    DRAIN  = 2'd1,
    LOAD   = 2'd2,
    RUN    = 2'd3
  } lut_state_e;

  // Number of entries in one neuron truth table.
  function automatic int table_depth(input int in_bits);
    return 1 << in_bits;
  endfunction

  // Width needed to count 0 .. n-1 (never narrower than one bit).
  function automatic int cnt_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

`ifdef LUT_PARITY_EN
  localparam int PARITY_BITS = 1;
`else
  localparam int PARITY_BITS = 0;
`endif

endpackage

// File: rtl/lut_neuron_ram.sv
// One neuron truth table: distributed RAM with synchronous write and a
// registered read port. The storage array has no reset; only the read
// register is cleared so the array output comes up as zero.
module lut_neuron_ram
  import lut_neuron_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = table_depth(ADDR_W);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Table write from the config stream.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Registered lookup; holds its value whenever no new beat moves in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/lut_neuron_array.sv
// Runtime-programmable array of LUT neurons with a two-stage valid/ready
// lookup pipeline and a serial table-load stream.
// Optional feature macro: LUT_PARITY_EN (per-entry parity, sticky parity_err).
module lut_neuron_array
  import lut_neuron_pkg::*;
#(
  parameter int N_NEURONS = 8,
  parameter int IN_BITS   = 8,
  parameter int OUT_BITS  = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [N_NEURONS*IN_BITS-1:0]  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [N_NEURONS*OUT_BITS-1:0] out_data,
  input  logic                          cfg_start,
  input  logic                          cfg_valid,
  output logic                          cfg_ready,
  input  logic [OUT_BITS-1:0]           cfg_data,
  output logic                          cfg_done,
  output logic                          busy,
  output logic                          parity_err
);

  localparam int DEPTH = table_depth(IN_BITS);
  localparam int NW    = cnt_width(N_NEURONS);
  localparam int EW    = OUT_BITS + PARITY_BITS;

  localparam logic [IN_BITS-1:0] ADDR_LAST   = IN_BITS'(DEPTH - 1);
  localparam logic [NW-1:0]      NEURON_LAST = NW'(N_NEURONS - 1);

  lut_state_e state_q, state_d;
  logic [IN_BITS-1:0] addr_cnt_q, addr_cnt_d;
  logic [NW-1:0]      neuron_cnt_q, neuron_cnt_d;
  logic               cfg_done_q, cfg_done_d;

  logic                         s1_valid_q;
  logic [N_NEURONS*IN_BITS-1:0] s1_addr_q;
  logic                         out_valid_q;

  logic          en;
  logic          accept;
  logic          rd_en;
  logic          cfg_wr;
  logic [EW-1:0] cfg_word;

  // The whole pipeline advances together unless the output beat is stuck.
  assign en     = !out_valid_q || out_ready;
  assign accept = in_valid && in_ready;
  // Only read when a beat moves into stage 2 so out_data is frozen otherwise.
  assign rd_en  = en && s1_valid_q;
  assign cfg_wr = (state_q == LOAD) && cfg_valid;

`ifdef LUT_PARITY_EN
  assign cfg_word = {^cfg_data, cfg_data};
`else
  assign cfg_word = cfg_data;
`endif

  // Next-state, load counters and handshake readies.
  always_comb begin
    state_d      = state_q;
    addr_cnt_d   = addr_cnt_q;
    neuron_cnt_d = neuron_cnt_q;
    cfg_done_d   = 1'b0;
    in_ready     = 1'b0;
    cfg_ready    = 1'b0;
    case (state_q)
      UNPROG: begin
        // Pipeline is necessarily empty here, so go straight to loading.
        if (cfg_start) begin
          state_d = LOAD;
        end
      end
      RUN: begin
        // A reload request takes priority over a same-cycle lookup.
        if (cfg_start) begin
          state_d = DRAIN;
        end else begin
          in_ready = en;
        end
      end
      DRAIN: begin
        if (!s1_valid_q && !out_valid_q) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cfg_ready = 1'b1;
        if (cfg_valid) begin
          if ((addr_cnt_q == ADDR_LAST) && (neuron_cnt_q == NEURON_LAST)) begin
            addr_cnt_d   = '0;
            neuron_cnt_d = '0;
            cfg_done_d   = 1'b1;
            state_d      = RUN;
          end else begin
            addr_cnt_d = addr_cnt_q + 1'b1;
            if (addr_cnt_q == ADDR_LAST) begin
              neuron_cnt_d = neuron_cnt_q + 1'b1;
            end
          end
        end
      end
      default: begin
        state_d = UNPROG;
      end
    endcase
  end

  // Controller state and load counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= UNPROG;
      addr_cnt_q   <= '0;
      neuron_cnt_q <= '0;
      cfg_done_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_cnt_q   <= addr_cnt_d;
      neuron_cnt_q <= neuron_cnt_d;
      cfg_done_q   <= cfg_done_d;
    end
  end

  // Stage-1 address capture and pipeline valid bits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_addr_q   <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (en) begin
        s1_valid_q  <= accept;
        out_valid_q <= s1_valid_q;
      end
      if (accept) begin
        s1_addr_q <= in_data;
      end
    end
  end

`ifdef LUT_PARITY_EN
  logic                 cfg_accept;
  logic [N_NEURONS-1:0] rd_par_bad;
  logic                 parity_err_q;

  assign cfg_accept = cfg_start && ((state_q == UNPROG) || (state_q == RUN));
`endif

  genvar gi;
  generate
    for (gi = 0; gi < N_NEURONS; gi++) begin : gen_neuron
      logic [EW-1:0] rdata;

      lut_neuron_ram #(
        .ADDR_W (IN_BITS),
        .DATA_W (EW)
      ) u_ram (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (cfg_wr && (neuron_cnt_q == NW'(gi))),
        .waddr_i (addr_cnt_q),
        .wdata_i (cfg_word),
        .re_i    (rd_en),
        .raddr_i (s1_addr_q[gi*IN_BITS +: IN_BITS]),
        .rdata_o (rdata)
      );

      assign out_data[gi*OUT_BITS +: OUT_BITS] = rdata[OUT_BITS-1:0];
`ifdef LUT_PARITY_EN
      // Stored word has even parity, so any odd XOR is corruption.
      assign rd_par_bad[gi] = ^rdata;
`endif
    end
  endgenerate

`ifdef LUT_PARITY_EN
  // Sticky error: set by a bad stage-2 word, cleared by an accepted reload.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_err_q <= 1'b0;
    end else if (cfg_accept) begin
      parity_err_q <= 1'b0;
    end else if (out_valid_q && (|rd_par_bad)) begin
      parity_err_q <= 1'b1;
    end
  end

  assign parity_err = parity_err_q;
`else
  assign parity_err = 1'b0;
`endif

  assign out_valid = out_valid_q;
  assign cfg_done  = cfg_done_q;
  assign busy      = (state_q != RUN);

endmodule
